// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared word/address types, LSU enums and helpers
//
// Purpose: types and helper functions for the load/store unit. Also holds
// the word-address and byte-mask macros and the TRACE hook.
// Ports: none (package).
`ifndef LOAD_STORE_UNIT_PKG_SV
`define LOAD_STORE_UNIT_PKG_SV

`define WORD_ADDRESS(addr) ((addr) & ~RamAddress'(3))
// Lane mask across a two-word window: cnt bytes starting at byte offset off.
`define BYTE_MASK(off, cnt) (8'((16'd1 << (cnt)) - 16'd1) << (off))

`ifndef TRACE
`define TRACE(msg)
`endif

package load_store_unit_pkg;

  typedef logic [31:0] Word;
  typedef logic [15:0] RamAddress;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } MemFunct3;

  typedef enum logic [1:0] {
    LSU_IDLE,
    LSU_ACCESS0,
    LSU_ACCESS1,
    LSU_RESP
  } LsuState;

  function automatic logic funct3_legal(input logic [2:0] funct3, input logic store);
    case (funct3)
      MEM_B, MEM_H, MEM_W: funct3_legal = 1'b1;
      MEM_BU, MEM_HU:      funct3_legal = !store;
      default:             funct3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   access_bytes = 3'd1;
      2'b01:   access_bytes = 3'd2;
      default: access_bytes = 3'd4;
    endcase
  endfunction

  // o + n > 4 means the access runs into the next word.
  function automatic logic access_spans(input logic [1:0] offset, input logic [2:0] count);
    access_spans = ({1'b0, offset} + count) > 3'd4;
  endfunction

  function automatic Word extend_load(input Word raw, input logic [2:0] funct3);
    case (funct3)
      MEM_B:   extend_load = {{24{raw[7]}}, raw[7:0]};
      MEM_H:   extend_load = {{16{raw[15]}}, raw[15:0]};
      MEM_BU:  extend_load = {24'd0, raw[7:0]};
      MEM_HU:  extend_load = {16'd0, raw[15:0]};
      default: extend_load = raw;
    endcase
  endfunction

endpackage

`endif

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request/response and ram bus bundle for the LSU
//
// Purpose: groups pipeline request/response and ram port signals.
// Modports: slave = the load/store unit, master = pipeline + ram side.
interface load_store_unit_if;
  import load_store_unit_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  RamAddress   req_address;
  Word         req_data;
  logic        resp_valid;
  logic        resp_error;
  Word         resp_data;
  logic        ram_write_enable;
  RamAddress   ram_address;
  Word         ram_in;
  Word         ram_out;

  modport slave (
    input  req_valid, req_store, req_funct3, req_address, req_data, ram_out,
    output req_ready, resp_valid, resp_error, resp_data,
           ram_write_enable, ram_address, ram_in
  );

  modport master (
    output req_valid, req_store, req_funct3, req_address, req_data, ram_out,
    input  req_ready, resp_valid, resp_error, resp_data,
           ram_write_enable, ram_address, ram_in
  );
endinterface

// File: rtl/lsu_lane_shifter.sv
// rtl/lsu_lane_shifter.sv - byte-lane merge/extract for one word of an access
//
// Purpose: for the word selected by 'second', finds the lanes the access
// touches, merges store bytes into 'word' and pulls load bytes out of it.
// Ports: offset (address[1:0]), count (1/2/4 bytes), second (word1 phase),
//        word (current ram word), data (store data), merged (store word),
//        extracted (load bytes placed at their result positions, rest 0).
module lsu_lane_shifter
  import load_store_unit_pkg::*;
(
  input  logic [1:0] offset,
  input  logic [2:0] count,
  input  logic       second,
  input  Word        word,
  input  Word        data,
  output Word        merged,
  output Word        extracted
);
  logic [7:0] span_mask;
  logic [3:0] lane_mask;
  logic [1:0] k;

  assign span_mask = `BYTE_MASK(offset, count);
  assign lane_mask = second ? span_mask[7:4] : span_mask[3:0];

  // Lane j carries data byte (j - offset) mod 4 in both words: word0 lanes
  // sit at j >= offset, word1 lanes wrap around below offset.
  always_comb begin
    merged    = word;
    extracted = '0;
    k         = '0;
    for (int j = 0; j < 4; j++) begin
      if (lane_mask[j]) begin
        k = 2'(j) - offset;
        merged[8*j +: 8]    = data[8*k +: 8];
        extracted[8*k +: 8] = word[8*j +: 8];
      end
    end
  end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store unit over a word-wide ram
//
// Purpose: runs one byte/half/word load or store per request as one or two
// whole-word ram cycles; sub-word stores are read-modify-write in one cycle.
// Ports: clk, reset (sync, active-high), bus (load_store_unit_if.slave:
//        req_* handshake, resp_* completion pulse, ram_* word port).
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  load_store_unit_if.slave bus
);
  LsuState    state, state_next;
  RamAddress  address_q;
  logic [2:0] funct3_q;
  logic       store_q;
  Word        data_q;
  Word        result_q;
  logic       error_q;

  logic [1:0] offset;
  logic [2:0] count;
  logic       spans;
  RamAddress  word0, word1;
  logic       req_legal;
  logic       transfer;
  Word        merged, extracted;

  assign offset    = address_q[1:0];
  assign count     = access_bytes(funct3_q);
  assign spans     = access_spans(offset, count);
  assign word0     = `WORD_ADDRESS(address_q);
  assign word1     = word0 + RamAddress'(4);  // wraps at the top of memory
  assign req_legal = funct3_legal(bus.req_funct3, bus.req_store);
  assign transfer  = bus.req_valid && bus.req_ready;

  lsu_lane_shifter u_lane_shifter (
    .offset    (offset),
    .count     (count),
    .second    (state == LSU_ACCESS1),
    .word      (bus.ram_out),
    .data      (data_q),
    .merged    (merged),
    .extracted (extracted)
  );

  always_comb begin
    state_next           = state;
    bus.req_ready        = 1'b0;
    bus.resp_valid       = 1'b0;
    bus.resp_error       = 1'b0;
    bus.resp_data        = '0;
    bus.ram_write_enable = 1'b0;
    bus.ram_address      = '0;
    bus.ram_in           = '0;
    case (state)
      LSU_IDLE: begin
        bus.req_ready = !reset;
        if (bus.req_valid && !reset) state_next = req_legal ? LSU_ACCESS0 : LSU_RESP;
      end
      LSU_ACCESS0, LSU_ACCESS1: begin
        bus.ram_address = (state == LSU_ACCESS0) ? word0 : word1;
        if (store_q) begin
          bus.ram_in = merged;
          // Reset drops a write that has not committed yet.
          bus.ram_write_enable = !reset;
        end
        state_next = (state == LSU_ACCESS0 && spans) ? LSU_ACCESS1 : LSU_RESP;
      end
      LSU_RESP: begin
        if (!reset) begin
          bus.resp_valid = 1'b1;
          bus.resp_error = error_q;
          bus.resp_data  = (error_q || store_q) ? '0 : extend_load(result_q, funct3_q);
          bus.req_ready  = 1'b1;
        end
        if (bus.req_valid && !reset) state_next = req_legal ? LSU_ACCESS0 : LSU_RESP;
        else                         state_next = LSU_IDLE;
      end
      default: state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LSU_IDLE;
      address_q <= '0;
      funct3_q  <= '0;
      store_q   <= 1'b0;
      data_q    <= '0;
      result_q  <= '0;
      error_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (transfer) begin
        address_q <= bus.req_address;
        funct3_q  <= bus.req_funct3;
        store_q   <= bus.req_store;
        data_q    <= bus.req_data;
        error_q   <= !req_legal;
        result_q  <= '0;
      end else if ((state == LSU_ACCESS0 || state == LSU_ACCESS1) && !store_q) begin
        result_q <= result_q | extracted;
      end
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  Word        mem     [0:16383];
  Word        ref_mem [0:16383];
  logic       poke_en;
  logic [13:0] poke_idx;
  Word        poke_val;

  assign bus.ram_out = mem[bus.ram_address[15:2]];

  always @(posedge clk) begin
    if (bus.ram_write_enable) mem[bus.ram_address[15:2]] <= bus.ram_in;
    else if (poke_en)         mem[poke_idx] <= poke_val;
  end

  int checks   = 0;
  int failures = 0;

  task automatic poke(input logic [13:0] idx, input Word val);
    poke_en  = 1'b1;
    poke_idx = idx;
    poke_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Byte-level memory model: expected result, error, latency and write count.
  task automatic model_access(input logic st, input logic [2:0] f3, input RamAddress a,
                              input Word d, output Word exp_data, output logic exp_err,
                              output int exp_lat, output int exp_wr);
    int n;
    RamAddress ba;
    Word raw;
    logic legal;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    exp_data = '0;
    raw = '0;
    if (!legal) begin
      exp_err = 1'b1;
      exp_lat = 1;
      exp_wr  = 0;
    end else begin
      exp_err = 1'b0;
      for (int i = 0; i < n; i++) begin
        ba = a + RamAddress'(i);
        if (st) ref_mem[ba[15:2]][8*ba[1:0] +: 8] = d[8*i +: 8];
        else    raw[8*i +: 8] = ref_mem[ba[15:2]][8*ba[1:0] +: 8];
      end
      if (!st) begin
        if (f3 == 3'd0)      exp_data = raw[7]  ? (raw | 32'hFFFFFF00) : raw;
        else if (f3 == 3'd1) exp_data = raw[15] ? (raw | 32'hFFFF0000) : raw;
        else                 exp_data = raw;
      end
      exp_lat = (int'(a[1:0]) + n > 4) ? 3 : 2;
      exp_wr  = st ? exp_lat - 1 : 0;
    end
  endtask

  // Called at a falling edge with the unit in IDLE or RESP; returns at the
  // falling edge where resp_valid is seen (lat = -1 on timeout).
  task automatic do_req(input logic st, input logic [2:0] f3, input RamAddress a, input Word d,
                        output Word rdata, output logic rerr, output int lat,
                        output int rdy_low, output int nwr);
    bus.req_valid   = 1'b1;
    bus.req_store   = st;
    bus.req_funct3  = f3;
    bus.req_address = a;
    bus.req_data    = d;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL req_ready_at_issue: got %b required 1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    rdata = '0; rerr = 1'b0; lat = -1; rdy_low = 0; nwr = 0;
    for (int c = 1; c <= 10; c++) begin
      if (bus.ram_write_enable === 1'b1) nwr++;
      if (bus.req_ready !== 1'b1) rdy_low++;
      if (bus.resp_valid === 1'b1) begin
        rdata = bus.resp_data;
        rerr  = bus.resp_error;
        lat   = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_store = 1'b0; bus.req_funct3 = '0;
    bus.req_address = '0; bus.req_data = '0;
    poke_en = 1'b0; poke_idx = '0; poke_val = '0;
    repeat (2) @(negedge clk);
    checks += 7;
    if (bus.req_ready !== 1'b0)        begin failures++; $display("FAIL reset_req_ready: got %b required 0", bus.req_ready); end
    if (bus.resp_valid !== 1'b0)       begin failures++; $display("FAIL reset_resp_valid: got %b required 0", bus.resp_valid); end
    if (bus.resp_error !== 1'b0)       begin failures++; $display("FAIL reset_resp_error: got %b required 0", bus.resp_error); end
    if (bus.resp_data !== 32'd0)       begin failures++; $display("FAIL reset_resp_data: got %h required 0", bus.resp_data); end
    if (bus.ram_write_enable !== 1'b0) begin failures++; $display("FAIL reset_ram_we: got %b required 0", bus.ram_write_enable); end
    if (bus.ram_address !== 16'd0)     begin failures++; $display("FAIL reset_ram_address: got %h required 0", bus.ram_address); end
    if (bus.ram_in !== 32'd0)          begin failures++; $display("FAIL reset_ram_in: got %h required 0", bus.ram_in); end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset: got %b required 1", bus.req_ready); end
  endtask

  task automatic test_byte_loads;
    RamAddress  addrs [3] = '{16'h3, 16'h7, 16'h7};
    logic [2:0] f3s   [3] = '{3'b000, 3'b000, 3'b100};
    Word        exps  [3] = '{32'h00000044, 32'hFFFFFF88, 32'h00000088};
    Word rd; logic er; int lat, rl, nw;
    poke(14'd0, 32'h44332211);
    poke(14'd1, 32'h88776655);
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, f3s[i], addrs[i], 32'h0, rd, er, lat, rl, nw);
      checks += 3;
      if (rd !== exps[i]) begin failures++; $display("FAIL byte_load_%0d_data: got %h required %h", i, rd, exps[i]); end
      if (lat != 2)       begin failures++; $display("FAIL byte_load_%0d_latency: got %0d required 2", i, lat); end
      if (er !== 1'b0)    begin failures++; $display("FAIL byte_load_%0d_error: got %b required 0", i, er); end
    end
  endtask

  task automatic test_spanning_load;
    Word rd; logic er; int lat, rl, nw;
    do_req(1'b0, 3'b010, 16'h2, 32'h0, rd, er, lat, rl, nw);
    checks += 3;
    if (rd !== 32'h66554433) begin failures++; $display("FAIL span_load_data: got %h required 66554433", rd); end
    if (lat != 3)            begin failures++; $display("FAIL span_load_latency: got %0d required 3", lat); end
    if (rl != 2)             begin failures++; $display("FAIL span_load_ready_low: got %0d required 2", rl); end
  endtask

  task automatic test_spanning_store;
    Word rd, ed; logic er, ee; int lat, rl, nw, el, ew;
    model_access(1'b1, 3'b001, 16'h3, 32'h1234BEEF, ed, ee, el, ew);
    do_req(1'b1, 3'b001, 16'h3, 32'h1234BEEF, rd, er, lat, rl, nw);
    checks += 5;
    if (mem[0] !== 32'hEF332211) begin failures++; $display("FAIL span_store_word0: got %h required EF332211", mem[0]); end
    if (mem[1] !== 32'h887766BE) begin failures++; $display("FAIL span_store_word1: got %h required 887766BE", mem[1]); end
    if (nw != 2)                 begin failures++; $display("FAIL span_store_writes: got %0d required 2", nw); end
    if (rd !== 32'd0)            begin failures++; $display("FAIL span_store_resp_data: got %h required 0", rd); end
    if (lat != 3)                begin failures++; $display("FAIL span_store_latency: got %0d required 3", lat); end
  endtask

  task automatic test_illegal;
    logic       sts [2] = '{1'b0, 1'b1};
    logic [2:0] f3s [2] = '{3'b011, 3'b100};
    Word rd; logic er; int lat, rl, nw;
    for (int i = 0; i < 2; i++) begin
      do_req(sts[i], f3s[i], 16'h4, 32'hA5A5A5A5, rd, er, lat, rl, nw);
      checks += 4;
      if (er !== 1'b1)  begin failures++; $display("FAIL illegal_%0d_error: got %b required 1", i, er); end
      if (lat != 1)     begin failures++; $display("FAIL illegal_%0d_latency: got %0d required 1", i, lat); end
      if (nw != 0)      begin failures++; $display("FAIL illegal_%0d_writes: got %0d required 0", i, nw); end
      if (rd !== 32'd0) begin failures++; $display("FAIL illegal_%0d_data: got %h required 0", i, rd); end
    end
    checks++;
    if (mem[1] !== 32'h887766BE) begin failures++; $display("FAIL illegal_store_memory: got %h required 887766BE", mem[1]); end
  endtask

  task automatic test_top_wrap;
    Word rd; logic er; int lat, rl, nw;
    poke(14'h3FFF, 32'h9A5B5C5D);
    do_req(1'b0, 3'b001, 16'hFFFF, 32'h0, rd, er, lat, rl, nw);
    checks += 2;
    if (rd !== 32'h0000119A) begin failures++; $display("FAIL top_wrap_data: got %h required 0000119A", rd); end
    if (lat != 3)            begin failures++; $display("FAIL top_wrap_latency: got %0d required 3", lat); end
  endtask

  task automatic test_reset_mid_store;
    logic saw_resp;
    @(negedge clk);
    poke(14'd0, 32'h44332211);
    poke(14'd1, 32'h88776655);
    bus.req_valid = 1'b1; bus.req_store = 1'b1; bus.req_funct3 = 3'b010;
    bus.req_address = 16'h2; bus.req_data = 32'hDEADBEEF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    saw_resp = bus.resp_valid;
    checks++;
    if (bus.ram_write_enable !== 1'b1) begin failures++; $display("FAIL mid_reset_access0_we: got %b required 1", bus.ram_write_enable); end
    @(negedge clk);
    reset = 1'b1;
    saw_resp = saw_resp | bus.resp_valid;
    @(negedge clk);
    saw_resp = saw_resp | bus.resp_valid;
    reset = 1'b0;
    @(negedge clk);
    saw_resp = saw_resp | bus.resp_valid;
    checks += 4;
    if (bus.req_ready !== 1'b1)  begin failures++; $display("FAIL mid_reset_ready: got %b required 1", bus.req_ready); end
    if (saw_resp !== 1'b0)       begin failures++; $display("FAIL mid_reset_resp_valid: got %b required 0", saw_resp); end
    if (mem[0] !== 32'hBEEF2211) begin failures++; $display("FAIL mid_reset_word0: got %h required BEEF2211", mem[0]); end
    if (mem[1] !== 32'h88776655) begin failures++; $display("FAIL mid_reset_word1: got %h required 88776655", mem[1]); end
    ref_mem[0] = 32'hBEEF2211;
  endtask

  task automatic test_random;
    Word rd, ed, d; logic er, ee, st; int lat, rl, nw, el, ew;
    logic [2:0] f3; RamAddress a;
    for (int w = 0; w < 16; w++) poke(14'(w), $urandom);
    for (int w = 16'h3FFC; w <= 16'h3FFF; w++) poke(14'(w), $urandom);
    for (int i = 0; i < 80; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? RamAddress'(16'hFFF0 + $urandom_range(0, 15))
                                       : RamAddress'($urandom_range(0, 59));
      d  = $urandom;
      model_access(st, f3, a, d, ed, ee, el, ew);
      do_req(st, f3, a, d, rd, er, lat, rl, nw);
      checks += 4;
      if (rd !== ed)  begin failures++; $display("FAIL random_%0d_data: st=%b f3=%b a=%h got %h required %h", i, st, f3, a, rd, ed); end
      if (er !== ee)  begin failures++; $display("FAIL random_%0d_error: got %b required %b", i, er, ee); end
      if (lat != el)  begin failures++; $display("FAIL random_%0d_latency: got %0d required %0d", i, lat, el); end
      if (nw != ew)   begin failures++; $display("FAIL random_%0d_writes: got %0d required %0d", i, nw, ew); end
      if ($urandom_range(0, 2) == 0) @(negedge clk);
    end
    for (int w = 0; w < 16; w++) begin
      checks++;
      if (mem[w] !== ref_mem[w]) begin failures++; $display("FAIL random_mem_%0d: got %h required %h", w, mem[w], ref_mem[w]); end
    end
    for (int w = 16'h3FFC; w <= 16'h3FFF; w++) begin
      checks++;
      if (mem[w] !== ref_mem[w]) begin failures++; $display("FAIL random_mem_%h: got %h required %h", w, mem[w], ref_mem[w]); end
    end
  endtask

  initial begin
    test_reset;
    test_byte_loads;
    test_spanning_load;
    test_spanning_store;
    test_illegal;
    test_top_wrap;
    test_reset_mid_store;
    test_random;
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the CPU pipeline and the data `ram`. It accepts one RISC-V load or store per request (byte, halfword or word, signed or unsigned, any alignment) and turns it into whole-word accesses on the `ram` port. `ram` reads asynchronously and writes whole words only, so sub-word stores are done as single-cycle read-modify-write. Accesses that cross a word boundary take two word cycles. The pipeline stalls on `req_ready`.

## Interface
Parameters:
- none; widths come from the shared `Word` (32 b) and `RamAddress` types.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; a request transfers when `req_valid && req_ready` at a rising edge.
- `req_store`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; BU/HU are legal for loads only.
- `req_address`  in  `RamAddress`  byte address.
- `req_data`  in  `Word`  store data; the low 1/2/4 bytes are used.
- `resp_valid`  out  1  one-cycle completion pulse; no backpressure.
- `resp_error`  out  1  valid with `resp_valid`; illegal funct3.
- `resp_data`  out  `Word`  sign- or zero-extended load result; 0 for stores and errors.
- `ram_write_enable`  out  1  drives `ram.write_enable`.
- `ram_address`  out  `RamAddress`  word-aligned (low 2 bits are 0).
- `ram_in`  out  `Word`  merged store word.
- `ram_out`  in  `Word`  asynchronous read data from `ram`.

## Operation
- Memory is little-endian. Offset o = address[1:0]. Size n = 1, 2 or 4 bytes.
- An access spans two words when o + n > 4. Word0 is at address & ~3. Word1 is at word0 + 4, computed modulo 2^$bits(RamAddress), so an access at the top of memory wraps to address 0.
- FSM states: IDLE, ACCESS0, ACCESS1, RESP.
- IDLE, on a transfer:
  - latch address, funct3, store flag and data;
  - if funct3 is illegal, go to RESP with the error flag set and make no ram access;
  - otherwise go to ACCESS0.
- ACCESS0:
  - drive `ram_address` = word0;
  - load: capture the bytes at offsets o..min(3, o+n-1) from `ram_out` as the low result bytes;
  - store: `ram_in` = `ram_out` with those lanes replaced by the low `req_data` bytes, `ram_write_enable` = 1;
  - go to ACCESS1 if the access spans, else RESP.
- ACCESS1:
  - same as ACCESS0 on word1 for the remaining bytes (offsets 0..o+n-5);
  - these bytes are the upper bytes of the result or data;
  - go to RESP.
- RESP:
  - `resp_valid` = 1;
  - `resp_data`: B/H are sign-extended from bit 7/15, BU/HU are zero-extended;
  - go to IDLE, or to the next request's first state if one transfers this cycle.
- `ram_write_enable` is 1 only in ACCESS0/ACCESS1 of a legal store.
- Unwritten lanes keep their previous `ram` contents.

## Timing
- Reset values: state IDLE, `req_ready` 0 while `reset` is high, `resp_valid` 0, `resp_error` 0, `resp_data` 0, `ram_write_enable` 0, `ram_address` 0, `ram_in` 0.
- `req_ready` = (state is IDLE or RESP) and not `reset`, so throughput is one request per 2 cycles (aligned).
- Latency, counting the transfer edge as cycle 0:
  - aligned or non-spanning access: ACCESS0 in cycle 1, `resp_valid` in cycle 2;
  - spanning access: `resp_valid` in cycle 3;
  - illegal funct3: `resp_valid` in cycle 1.
- Store writes commit at the rising edge that ends each ACCESS cycle.
- `ram_*` outputs are combinational from the FSM state and latched registers. They never depend combinationally on `req_*`.
- Reset mid-operation: return to IDLE at the next edge and issue no response.
  - A word0 write already committed in ACCESS0 stays in memory.
  - A pending word1 write is dropped.
- A request presented in RESP is accepted in the same cycle as the response.

## Structure
- Add to the shared types package:
  - `MemFunct3` enum (B, H, W, BU, HU);
  - `LsuState` enum;
  - a byte-mask helper macro next to `WORD_ADDRESS`.
- Sub-module `lsu_lane_shifter` (combinational):
  - given offset, byte count and a word, produces the merged store word and the extracted load bytes;
  - instantiated once and reused for both ACCESS states.
- Include guard and `TRACE` hook as in the other units.

## Test plan
Preload `ram`: 0x0 = 0x44332211, 0x4 = 0x88776655.
- LB at 0x3 -> `resp_data` 0x00000044. LB at 0x7 -> 0xFFFFFF88. LBU at 0x7 -> 0x00000088. Each `resp_valid` is 2 cycles after the transfer.
- LW at 0x2 -> 0x66554433, `resp_valid` 3 cycles after the transfer, `req_ready` low for 2 cycles.
- SH with data 0x1234BEEF at 0x3 -> afterwards 0x0 = 0xEF332211 and 0x4 = 0x887766BE. Exactly two write cycles. `resp_data` = 0.
- funct3 = 011 load, and SBU (100 with store) -> `resp_error` = 1 one cycle after the transfer. No `ram_write_enable` pulse.
- LH at the top address (all ones, offset 3) -> low byte from the top word, high byte from word 0x0 (0x11). Result = sign-extended {0x11, top byte}.
- SW 0xDEADBEEF at 0x2 with `reset` asserted during ACCESS1 -> 0x0 = 0xBEEF2211, 0x4 unchanged. No `resp_valid`. `req_ready` = 1 the cycle after `reset` falls.
